// File: rtl/morse_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : morse_rx_if
// Description : Character output channel of the Morse receiver. Carries the
//               decoded character with its valid/ready handshake and the
//               sticky overrun flag with its clear strobe.
// Revision    : 1.0 - initial release
// ============================================================================
interface morse_rx_if;
    logic [7:0] ascii_out;
    logic       valid;
    logic       ready;
    logic       overrun;
    logic       clr_overrun;

    // Receiver side: produces characters and the overrun flag
    modport master (
        output ascii_out,
        output valid,
        output overrun,
        input  ready,
        input  clr_overrun
    );

    // Consumer side
    modport slave (
        input  ascii_out,
        input  valid,
        input  overrun,
        output ready,
        output clr_overrun
    );
endinterface
`default_nettype wire

// File: rtl/morse_rx.sv
`default_nettype none
// ============================================================================
// Module      : morse_rx
// Description : Morse receiver/decoder. Synchronises the keyed line, measures
//               mark/space lengths in unit ticks placed at mid-unit, classifies
//               dots and dashes, detects letter and word gaps and emits
//               uppercase ASCII through a one-entry holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_SYMBOLS = 6
) (
    input  wire logic        clk,
    input  wire logic        arst_n,
    input  wire logic        morse_in,
    input  wire logic [31:0] prescaler,
    morse_rx_if.master       rx
);

    localparam int c_LEN_W = $clog2(MAX_SYMBOLS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MARK = 2'd1,
        ST_GAP  = 2'd2,
        ST_WORD = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_prev;
    logic [31:0]            r_phase;
    logic [3:0]             r_run;
    state_t                 r_state;
    logic [MAX_SYMBOLS-1:0] r_bits;
    logic [c_LEN_W-1:0]     r_len;
    logic                   r_err;
    logic                   r_emit;
    logic [7:0]             r_emit_char;
    logic [7:0]             r_ascii;
    logic                   r_valid;
    logic                   r_overrun;

    logic        w_s_in;
    logic        w_edge;
    logic        w_rise;
    logic        w_fall;
    logic [31:0] w_period;
    logic [31:0] w_half;
    logic        w_tick;
    logic        w_sym;
    logic [5:0]  w_pat6;
    logic [2:0]  w_len3;
    logic        w_len_fit;
    logic [7:0]  w_lookup;
    logic        w_drop;

    assign w_s_in = r_sync[SYNC_STAGES-1];
    assign w_edge = w_s_in ^ r_s_prev;
    assign w_rise = w_s_in & ~r_s_prev;
    assign w_fall = ~w_s_in & r_s_prev;

    // Unit period; 0 and 1 both mean a single cycle
    assign w_period = (prescaler < 32'd2) ? 32'd1 : prescaler;
    assign w_half   = (w_period[31:1] == 31'd0) ? 32'd1 : {1'b0, w_period[31:1]};
    // An edge restarts the unit grid, so a tick on that same cycle is void
    assign w_tick   = (r_phase == 32'd1) & ~w_edge;
    // Marks of three or more units are dashes
    assign w_sym    = (r_run >= 4'd3);

    // Two-flop (or deeper) synchroniser plus previous-sample register for edges
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_sync   <= '0;
            r_s_prev <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], morse_in};
            r_s_prev <= w_s_in;
        end
    end

    // Mid-unit tick phase and saturating run length in ticks since last edge
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_phase <= 32'd0;
            r_run   <= 4'd0;
        end else begin
            if (w_edge) begin
                r_phase <= w_half;
            end else if (r_phase <= 32'd1) begin
                r_phase <= w_period;
            end else begin
                r_phase <= r_phase - 32'd1;
            end

            if (w_edge) begin
                r_run <= 4'd0;
            end else if (w_tick && (r_run != 4'd15)) begin
                r_run <= r_run + 4'd1;
            end
        end
    end

    // Pattern as len symbols right-aligned, first symbol most significant
    generate
        if (MAX_SYMBOLS >= 6) begin : g_pat_trunc
            assign w_pat6 = r_bits[5:0];
        end else begin : g_pat_ext
            assign w_pat6 = {{(6 - MAX_SYMBOLS){1'b0}}, r_bits};
        end
    endgenerate

    assign w_len_fit = (32'(r_len) <= 32'd6);
    assign w_len3    = 3'(r_len);

    // Symbol pattern to ASCII; 1 = dash, anything unknown decodes as '?'
    always_comb begin
        w_lookup = 8'h3F;
        if (!r_err && w_len_fit) begin
            case ({w_len3, w_pat6})
                {3'd2, 6'b000001}: w_lookup = 8'h41; // A .-
                {3'd4, 6'b001000}: w_lookup = 8'h42; // B -...
                {3'd4, 6'b001010}: w_lookup = 8'h43; // C -.-.
                {3'd3, 6'b000100}: w_lookup = 8'h44; // D -..
                {3'd1, 6'b000000}: w_lookup = 8'h45; // E .
                {3'd4, 6'b000010}: w_lookup = 8'h46; // F ..-.
                {3'd3, 6'b000110}: w_lookup = 8'h47; // G --.
                {3'd4, 6'b000000}: w_lookup = 8'h48; // H ....
                {3'd2, 6'b000000}: w_lookup = 8'h49; // I ..
                {3'd4, 6'b000111}: w_lookup = 8'h4A; // J .---
                {3'd3, 6'b000101}: w_lookup = 8'h4B; // K -.-
                {3'd4, 6'b000100}: w_lookup = 8'h4C; // L .-..
                {3'd2, 6'b000011}: w_lookup = 8'h4D; // M --
                {3'd2, 6'b000010}: w_lookup = 8'h4E; // N -.
                {3'd3, 6'b000111}: w_lookup = 8'h4F; // O ---
                {3'd4, 6'b000110}: w_lookup = 8'h50; // P .--.
                {3'd4, 6'b001101}: w_lookup = 8'h51; // Q --.-
                {3'd3, 6'b000010}: w_lookup = 8'h52; // R .-.
                {3'd3, 6'b000000}: w_lookup = 8'h53; // S ...
                {3'd1, 6'b000001}: w_lookup = 8'h54; // T -
                {3'd3, 6'b000001}: w_lookup = 8'h55; // U ..-
                {3'd4, 6'b000001}: w_lookup = 8'h56; // V ...-
                {3'd3, 6'b000011}: w_lookup = 8'h57; // W .--
                {3'd4, 6'b001001}: w_lookup = 8'h58; // X -..-
                {3'd4, 6'b001011}: w_lookup = 8'h59; // Y -.--
                {3'd4, 6'b001100}: w_lookup = 8'h5A; // Z --..
                {3'd5, 6'b011111}: w_lookup = 8'h30; // 0 -----
                {3'd5, 6'b001111}: w_lookup = 8'h31; // 1 .----
                {3'd5, 6'b000111}: w_lookup = 8'h32; // 2 ..---
                {3'd5, 6'b000011}: w_lookup = 8'h33; // 3 ...--
                {3'd5, 6'b000001}: w_lookup = 8'h34; // 4 ....-
                {3'd5, 6'b000000}: w_lookup = 8'h35; // 5 .....
                {3'd5, 6'b010000}: w_lookup = 8'h36; // 6 -....
                {3'd5, 6'b011000}: w_lookup = 8'h37; // 7 --...
                {3'd5, 6'b011100}: w_lookup = 8'h38; // 8 ---..
                {3'd5, 6'b011110}: w_lookup = 8'h39; // 9 ----.
                {3'd6, 6'b010101}: w_lookup = 8'h2E; // . .-.-.-
                {3'd6, 6'b110011}: w_lookup = 8'h2C; // , --..--
                {3'd6, 6'b001100}: w_lookup = 8'h3F; // ? ..--..
                {3'd5, 6'b010010}: w_lookup = 8'h2F; // / -..-.
                default:           w_lookup = 8'h3F;
            endcase
        end
    end

    // Receive state machine: symbol accumulation, letter and word gap emits
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state     <= ST_IDLE;
            r_bits      <= '0;
            r_len       <= '0;
            r_err       <= 1'b0;
            r_emit      <= 1'b0;
            r_emit_char <= 8'h00;
        end else begin
            r_emit <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state <= ST_MARK;
                    end
                end
                ST_MARK: begin
                    if (w_fall) begin
                        if (r_run == 4'd0) begin
                            // Sub-tick pulse: leave the symbols untouched
                            r_state <= (r_len == '0) ? ST_IDLE : ST_GAP;
                        end else begin
                            if (r_len == c_LEN_W'(MAX_SYMBOLS)) begin
                                r_err <= 1'b1;
                            end else begin
                                r_bits <= (r_bits << 1) | MAX_SYMBOLS'(w_sym);
                                r_len  <= r_len + c_LEN_W'(1);
                            end
                            r_state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_rise) begin
                        r_state <= ST_MARK;
                    end else if (w_tick && (r_run == 4'd2)) begin
                        r_emit      <= 1'b1;
                        r_emit_char <= w_lookup;
                        r_bits      <= '0;
                        r_len       <= '0;
                        r_err       <= 1'b0;
                        r_state     <= ST_WORD;
                    end
                end
                ST_WORD: begin
                    if (w_rise) begin
                        r_state <= ST_MARK;
                    end else if (w_tick && (r_run == 4'd6)) begin
                        r_emit      <= 1'b1;
                        r_emit_char <= 8'h20;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A character arriving while an unread one is held and not being taken
    assign w_drop = r_emit & r_valid & ~rx.ready;

    // One-entry holding register with valid/ready and sticky overrun
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_ascii   <= 8'h00;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (r_emit && !w_drop) begin
                r_ascii <= r_emit_char;
                r_valid <= 1'b1;
            end else if (r_valid && rx.ready) begin
                r_valid <= 1'b0;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (rx.clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign rx.ascii_out = r_ascii;
    assign rx.valid     = r_valid;
    assign rx.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_morse_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_rx
// Description : Self-checking bench for morse_rx. Keys text at chosen unit
//               lengths and compares the received characters with the text
//               expected from Morse timing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_rx;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        morse_in;
    logic [31:0] prescaler;

    morse_rx_if bus ();

    morse_rx #(
        .SYNC_STAGES (2),
        .MAX_SYMBOLS (6)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .morse_in  (morse_in),
        .prescaler (prescaler),
        .rx        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    ps;
        string key;
        string exp;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    byte  got[$];
    bit   auto_ready = 1'b1;
    bit   man_ready  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // International Morse code of one character
    function automatic string morse_of(input byte c);
        case (c)
            "A": return ".-";     "B": return "-...";   "C": return "-.-.";
            "D": return "-..";    "E": return ".";      "F": return "..-.";
            "G": return "--.";    "H": return "....";   "I": return "..";
            "J": return ".---";   "K": return "-.-";    "L": return ".-..";
            "M": return "--";     "N": return "-.";     "O": return "---";
            "P": return ".--.";   "Q": return "--.-";   "R": return ".-.";
            "S": return "...";    "T": return "-";      "U": return "..-";
            "V": return "...-";   "W": return ".--";    "X": return "-..-";
            "Y": return "-.--";   "Z": return "--..";
            "0": return "-----";  "1": return ".----";  "2": return "..---";
            "3": return "...--";  "4": return "....-";  "5": return ".....";
            "6": return "-....";  "7": return "--...";  "8": return "---..";
            "9": return "----.";
            ".": return ".-.-.-"; ",": return "--..--"; "?": return "..--..";
            "/": return "-..-.";
            default: return "";
        endcase
    endfunction

    // Consumer: chooses ready, then records a transfer for the coming edge
    initial begin
        int  low_cnt;
        bit  r;
        low_cnt = 0;
        forever begin
            @(negedge clk);
            if (auto_ready) begin
                r = (low_cnt >= 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
                low_cnt = r ? 0 : low_cnt + 1;
                bus.ready = r;
            end else begin
                bus.ready = man_ready;
            end
            if (bus.valid && bus.ready && arst_n) got.push_back(bus.ascii_out);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic units(input logic level, input int n);
        int p;
        p = (prescaler < 2) ? 1 : int'(prescaler);
        morse_in = level;
        repeat (n * p) @(negedge clk);
    endtask

    // Key string: '.' dot, '-' dash (each with a 1-unit space), ' ' +2 units,
    // '_' +6 units, '#' +13 units; a 10-unit idle tail always follows
    task automatic play(input int ps, input string key);
        prescaler = ps;
        @(negedge clk);
        for (int i = 0; i < key.len(); i++) begin
            case (key[i])
                ".": begin units(1'b1, 1); units(1'b0, 1); end
                "-": begin units(1'b1, 3); units(1'b0, 1); end
                " ": units(1'b0, 2);
                "_": units(1'b0, 6);
                "#": units(1'b0, 13);
                default: ;
            endcase
        end
        units(1'b0, 10);
        repeat (10) @(negedge clk);
    endtask

    task automatic compare_got(input string name, input string exp);
        int n;
        chk({name, " count"}, got.size(), exp.len());
        n = (got.size() < exp.len()) ? got.size() : exp.len();
        for (int i = 0; i < n; i++) chk($sformatf("%s char%0d", name, i), got[i], exp[i]);
        got.delete();
    endtask

    initial begin
        vec_t  vecs[5];
        string cs;
        string key;
        string exp;
        int    nw;
        int    nc;
        byte   c;

        vecs[0] = '{4, ".",              "E "};
        vecs[1] = '{8, "... --- ...",    "SOS "};
        vecs[2] = '{6, ".-_-...",        "A B "};
        vecs[3] = '{6, ".-#-...",        "A B "};
        vecs[4] = '{4, "....... .-.- -", "??T "};

        arst_n          = 1'b0;
        morse_in        = 1'b0;
        prescaler       = 32'd4;
        bus.clr_overrun = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset ascii_out", bus.ascii_out, 8'h00);
        chk("reset valid", bus.valid, 1'b0);
        chk("reset overrun", bus.overrun, 1'b0);
        arst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Directed vectors
        for (int v = 0; v < 5; v++) begin
            got.delete();
            play(vecs[v].ps, vecs[v].key);
            compare_got($sformatf("vec%0d", v), vecs[v].exp);
            chk($sformatf("vec%0d overrun", v), bus.overrun, 1'b0);
        end

        // Consumer stalled: E held, T and space dropped
        auto_ready = 1'b0;
        man_ready  = 1'b0;
        repeat (2) @(negedge clk);
        got.delete();
        play(4, ". -");
        chk("stall valid", bus.valid, 1'b1);
        chk("stall ascii_out", bus.ascii_out, 8'h45);
        chk("stall overrun", bus.overrun, 1'b1);
        chk("stall no transfer", got.size(), 0);
        @(posedge clk); #1 man_ready = 1'b1;
        @(posedge clk); #1 man_ready = 1'b0;
        repeat (3) @(negedge clk);
        compare_got("stall release", "E");
        chk("stall valid after accept", bus.valid, 1'b0);
        chk("overrun sticky", bus.overrun, 1'b1);
        @(posedge clk); #1 bus.clr_overrun = 1'b1;
        @(posedge clk); #1 bus.clr_overrun = 1'b0;
        @(negedge clk);
        chk("overrun cleared", bus.overrun, 1'b0);

        // One-cycle glitch on an idle line
        auto_ready = 1'b1;
        prescaler  = 32'd8;
        @(negedge clk) morse_in = 1'b1;
        @(negedge clk) morse_in = 1'b0;
        repeat (200) @(negedge clk);
        chk("glitch no output", got.size(), 0);
        chk("glitch valid", bus.valid, 1'b0);

        // Asynchronous reset in the middle of a dash
        auto_ready = 1'b0;
        repeat (2) @(negedge clk);
        got.delete();
        play(8, ".");
        chk("pre-reset valid", bus.valid, 1'b1);
        chk("pre-reset overrun", bus.overrun, 1'b1);
        units(1'b1, 3);
        units(1'b0, 1);
        morse_in = 1'b1;
        repeat (12) @(negedge clk);
        @(posedge clk);
        #2 arst_n = 1'b0;
        #1;
        chk("async reset ascii_out", bus.ascii_out, 8'h00);
        chk("async reset valid", bus.valid, 1'b0);
        chk("async reset overrun", bus.overrun, 1'b0);
        morse_in = 1'b0;
        repeat (4) @(negedge clk);
        arst_n = 1'b1;
        auto_ready = 1'b1;
        repeat (10) @(negedge clk);
        got.delete();
        play(8, "-.-");
        compare_got("after reset K", "K ");

        // Random text keyed at random unit lengths
        cs = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789.,?/";
        for (int m = 0; m < 6; m++) begin
            key = "";
            exp = "";
            nw  = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++) begin
                nc = $urandom_range(1, 4);
                for (int k = 0; k < nc; k++) begin
                    c   = cs[$urandom_range(0, cs.len() - 1)];
                    key = {key, morse_of(c)};
                    exp = $sformatf("%s%c", exp, c);
                    if (k != nc - 1) key = {key, " "};
                end
                exp = {exp, " "};
                if (w != nw - 1) key = {key, ($urandom_range(0, 1) != 0) ? "_" : "#"};
            end
            got.delete();
            play($urandom_range(2, 8), key);
            compare_got($sformatf("rand%0d", m), exp);
            chk($sformatf("rand%0d overrun", m), bus.overrun, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
